// File: rtl/stack_cmd_sequencer.sv
// Push/pop command front-end for a DEPTH-entry LIFO stack: handshake, stack strobes, bus drive, occupancy.
// Optional macro STACK_CHECK_EN enables a sticky FULL/EMPTY versus depth consistency flag (sync_err).
module stack_cmd_sequencer #(
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [DW-1:0]                cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DW-1:0]                rsp_data,
  output logic                         rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  inout  wire  [DW-1:0]                IO,
  output logic                         EN,
  output logic                         PUSH_POP,
  output logic                         RW,
  output logic                         W_EN,
  input  logic                         FULL,
  input  logic                         EMPTY,
  output logic                         sync_err
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LP_FULL = AW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_PUSH, ST_POP, ST_RESP} state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_data;
  logic [DW-1:0]   r_rsp_data;
  logic            r_rsp_err;
  logic [AW-1:0]   r_depth;
  logic            w_full, w_empty;

  assign w_full  = (r_depth == LP_FULL);
  assign w_empty = (r_depth == '0);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    EN        = 1'b0;
    PUSH_POP  = 1'b0;
    RW        = 1'b0;
    W_EN      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op) w_next = w_full  ? ST_RESP : ST_PUSH;
          else        w_next = w_empty ? ST_RESP : ST_POP;
        end
      end
      ST_PUSH: begin
        EN       = 1'b1;
        PUSH_POP = 1'b1;
        W_EN     = 1'b1;
        w_next   = ST_RESP;
      end
      ST_POP: begin
        EN     = 1'b1;
        RW     = 1'b1;
        w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data     <= '0;
      r_depth    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_data <= cmd_data;
            // Rejected commands go straight to RESP, so the error response is set here.
            if ((cmd_op && w_full) || (!cmd_op && w_empty)) begin
              r_rsp_err  <= 1'b1;
              r_rsp_data <= '0;
            end
          end
        end
        ST_PUSH: begin
          r_depth    <= r_depth + AW'(1);
          r_rsp_err  <= 1'b0;
          r_rsp_data <= '0;
        end
        ST_POP: begin
          r_depth    <= r_depth - AW'(1);
          r_rsp_err  <= 1'b0;
          r_rsp_data <= IO;
        end
        default: ;
      endcase
    end
  end

  assign IO       = (r_state == ST_PUSH) ? r_data : 'z;
  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign depth    = r_depth;

`ifdef STACK_CHECK_EN
  logic r_sync_err;

  always_ff @(posedge CLK) begin
    if (RESET)
      r_sync_err <= 1'b0;
    else if ((r_state == ST_IDLE) && ((FULL != w_full) || (EMPTY != w_empty)))
      r_sync_err <= 1'b1;
  end

  assign sync_err = r_sync_err;
`else
  logic w_unused_flags;

  assign w_unused_flags = FULL ^ EMPTY;
  assign sync_err       = 1'b0;
`endif

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Randomized bench for stack_cmd_sequencer with a behavioural LIFO stack device and a queue-based reference.
module tb_stack_cmd_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
`ifdef STACK_CHECK_EN
  localparam logic EXP_SYNC = 1'b1;
`else
  localparam logic EXP_SYNC = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [5:0]    depth;
  wire  [DW-1:0] io_bus;
  logic          EN, PUSH_POP, RW, W_EN, FULL, EMPTY, sync_err;

  int n_checks = 0;
  int n_errors = 0;

  // Stack device: storage and pointer move on every EN cycle, like the real LIFO.
  logic [DW-1:0] mem [DEPTH];
  int            sp;
  logic          force_empty0;

  // Reference: expected stack contents after each accepted command.
  logic [DW-1:0] exp_q [$];

  always #5 CLK = ~CLK;

  stack_cmd_sequencer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .depth(depth), .IO(io_bus),
    .EN(EN), .PUSH_POP(PUSH_POP), .RW(RW), .W_EN(W_EN),
    .FULL(FULL), .EMPTY(EMPTY), .sync_err(sync_err)
  );

  assign io_bus = (EN && RW && sp > 0) ? mem[sp-1] : 'z;
  assign FULL   = (sp == DEPTH);
  assign EMPTY  = force_empty0 ? 1'b0 : (sp == 0);

  always @(posedge CLK) begin
    if (RESET) sp <= 0;
    else if (EN && W_EN && sp < DEPTH) begin
      mem[sp] <= io_bus;
      sp      <= sp + 1;
    end else if (EN && RW && sp > 0) sp <= sp - 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_strobes"}, {28'd0, EN, PUSH_POP, RW, W_EN}, 32'd0);
    check_eq({tag, "_io_z"}, 32'(io_bus), 32'(8'hzz));
    check_eq({tag, "_depth"}, 32'(depth), 32'(exp_q.size()));
  endtask

  // Issue one command from IDLE, hold the response for 'hold' cycles, optionally
  // pulsing cmd_valid while the response is pending.
  task automatic do_cmd(input logic op, input logic [DW-1:0] data, input int hold, input bit poke);
    logic          legal;
    logic [DW-1:0] e_data;
    logic          e_err;
    int            pre_depth;
    check_eq("accept_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    pre_depth = exp_q.size();
    legal     = op ? (pre_depth < DEPTH) : (pre_depth > 0);
    e_err     = ~legal;
    e_data    = '0;
    if (legal) begin
      check_eq("strobe_en", 32'(EN), 32'd1);
      check_eq("strobe_dir", {29'd0, PUSH_POP, RW, W_EN}, op ? 32'b101 : 32'b010);
      check_eq("strobe_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("strobe_depth", 32'(depth), 32'(pre_depth));
      if (op) begin
        check_eq("push_io", 32'(io_bus), 32'(data));
        exp_q.push_back(data);
      end else begin
        e_data = exp_q.pop_back();
        check_eq("pop_io", 32'(io_bus), 32'(e_data));
      end
      tick();
    end else begin
      check_eq("err_no_strobe", 32'(EN), 32'd0);
    end
    for (int i = 0; i <= hold; i++) begin
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_data", 32'(rsp_data), 32'(e_data));
      check_eq("rsp_err", 32'(rsp_err), 32'(e_err));
      check_eq("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("rsp_en", 32'(EN), 32'd0);
      check_eq("rsp_io_z", 32'(io_bus), 32'(8'hzz));
      check_eq("rsp_depth", 32'(depth), 32'(exp_q.size()));
      if (i < hold) begin
        if (poke && i == 0) begin
          cmd_valid = 1'b1;
          cmd_op    = 1'($urandom_range(0, 1));
          cmd_data  = 8'($urandom);
        end
        tick();
        cmd_valid = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_idle("after_rsp");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0;
    rsp_ready = 1'b0; force_empty0 = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    check_idle("reset");
    check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("reset_sync_err", 32'(sync_err), 32'd0);

    // Directed: single push, then LIFO ordering.
    do_cmd(1'b1, 8'hA5, 0, 0);
    do_cmd(1'b0, 8'h00, 0, 0);
    do_cmd(1'b1, 8'h11, 0, 0);
    do_cmd(1'b1, 8'h22, 0, 0);
    do_cmd(1'b1, 8'h33, 0, 0);
    repeat (3) do_cmd(1'b0, 8'h00, 0, 0);

    // Underflow, fill to capacity, overflow.
    do_cmd(1'b0, 8'h00, 0, 0);
    repeat (DEPTH) do_cmd(1'b1, 8'($urandom), 0, 0);
    do_cmd(1'b1, 8'hFF, 0, 0);
    check_eq("full_depth", 32'(depth), 32'(DEPTH));

    // Backpressure with an ignored command pulse.
    do_cmd(1'b0, 8'h00, 5, 1);
    do_cmd(1'b1, 8'h5C, 5, 1);

    // Randomized traffic, push-heavy then pop-heavy.
    for (int n = 0; n < 240; n++) begin
      logic op;
      op = ($urandom_range(0, 99) < ((n < 120) ? 70 : 30));
      do_cmd(op, 8'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    // Reset during the PUSH cycle.
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = 8'h77;
    while (exp_q.size() >= DEPTH) void'(exp_q.pop_back());
    if (depth >= 6'(DEPTH)) begin
      cmd_valid = 1'b0;
      do_cmd(1'b0, 8'h00, 0, 0);
      cmd_valid = 1'b1;
    end
    tick();
    cmd_valid = 1'b0;
    check_eq("pre_reset_push_en", 32'(EN), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_q.delete();
    check_idle("mid_push_reset");
    do_cmd(1'b0, 8'h00, 0, 0);

    // Stack flag disagreement in IDLE.
    check_eq("sync_clean", 32'(sync_err), 32'd0);
    force_empty0 = 1'b1;
    tick();
    force_empty0 = 1'b0;
    check_eq("sync_set", 32'(sync_err), 32'(EXP_SYNC));
    tick(); tick(); tick();
    check_eq("sync_held", 32'(sync_err), 32'(EXP_SYNC));
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_eq("sync_cleared", 32'(sync_err), 32'd0);
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_cmd_sequencer.md
Name: stack_cmd_sequencer

Overview:
Command front-end that sits directly upstream of the 32-entry, 8-bit LIFO stack. It accepts push/pop commands over a valid/ready handshake and generates the stack's one-cycle EN/PUSH_POP/RW/W_EN strobes. It drives and releases the shared bidirectional data bus and tracks occupancy independently. Every command returns exactly one response, carrying pop data or an overflow/underflow error.

Parameters:
DW, 8, data width of command, response and stack bus
DEPTH, 32, stack capacity in entries; occupancy counter is 6 bits wide, holding 0..DEPTH

Ports:
CLK  input  1  single clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  1  1 = push, 0 = pop
cmd_data  input  DW  push data; ignored for pop
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  DW  popped value; 0 for push responses and for errors
rsp_err  output  1  1 = push while full, or pop while empty
depth  output  6  current occupancy
IO  inout  DW  stack data bus; driven only in PUSH state, otherwise high-Z
EN  output  1  stack enable strobe
PUSH_POP  output  1  1 = push, 0 = pop; valid while EN = 1
RW  output  1  1 = read (pop)
W_EN  output  1  write enable (push)
FULL  input  1  stack full flag
EMPTY  input  1  stack empty flag
sync_err  output  1  sticky flag: stack flags disagree with depth

Behaviour:
- Reset: on a RESET-high edge, state goes to IDLE.
  - cmd_ready = 1; rsp_valid = 0, rsp_err = 0, rsp_data = 0.
  - depth = 0; EN = PUSH_POP = RW = W_EN = 0; IO high-Z; sync_err = 0.
  - Reset mid-operation aborts the operation at that edge and drops any pending response. The stack shares RESET, so both sides return to empty together.
- FSM states: IDLE, PUSH, POP, RESP.
- IDLE:
  - cmd_ready = 1; all strobes 0.
  - A command is accepted when cmd_valid & cmd_ready; cmd_op and cmd_data are registered.
  - Push with depth < DEPTH -> PUSH.
  - Push with depth == DEPTH -> RESP with rsp_err = 1; no strobe; depth unchanged.
  - Pop with depth > 0 -> POP.
  - Pop with depth == 0 -> RESP with rsp_err = 1, rsp_data = 0; no strobe.
- PUSH (exactly 1 cycle):
  - EN = 1, PUSH_POP = 1, W_EN = 1, RW = 0; IO driven with the registered data.
  - At the end of the cycle: depth + 1; rsp_err = 0, rsp_data = 0; -> RESP.
- POP (exactly 1 cycle):
  - EN = 1, PUSH_POP = 0, RW = 1, W_EN = 0; IO released.
  - IO is sampled into rsp_data on the edge that ends the cycle; depth - 1; rsp_err = 0; -> RESP.
- RESP:
  - cmd_ready = 0, rsp_valid = 1.
  - rsp_data and rsp_err hold stable until rsp_ready = 1; then -> IDLE with rsp_valid = 0 on the following cycle.
- Strobes are never asserted for more than one consecutive cycle, because the stack pointer moves on every EN cycle.
- Latency from command accept to rsp_valid: 2 cycles for a legal command, 1 cycle for an error. Best-case throughput is one command per 3 cycles.
- cmd_valid is ignored outside IDLE. rsp_ready is ignored outside RESP.
- depth never wraps: increments only from PUSH, decrements only from POP.
- IO is high-Z in every state except PUSH; there is no driven cycle adjacent to POP.

Optional Feature:
STACK_CHECK_EN
- Defined: in IDLE, compare FULL against (depth == DEPTH) and EMPTY against (depth == 0). Any mismatch sets sync_err on the next edge; it stays set until RESET. Commands are still processed normally.
- Undefined: sync_err is tied to 0, and FULL and EMPTY are unused.

Test Plan:
- Reset, then push 0xA5 -> one cycle with EN = 1, PUSH_POP = 1, W_EN = 1, IO = 0xA5; rsp_valid 2 cycles after accept with rsp_err = 0, rsp_data = 0; depth = 1.
- Push 0x11, 0x22, 0x33, then pop 3 times -> rsp_data = 0x33, 0x22, 0x11; depth returns to 0; each pop has exactly one EN cycle with RW = 1 and IO high-Z.
- Pop on an empty stack -> rsp_err = 1, rsp_data = 0, no EN pulse, depth stays 0. Push 32 times, then a 33rd push 0xFF -> rsp_err = 1, no EN pulse, depth stays 32.
- Hold rsp_ready = 0 for 5 cycles after a pop -> rsp_valid, rsp_data and rsp_err stay stable; cmd_ready = 0 throughout; a cmd_valid pulse in that window is not accepted.
- Assert RESET during the PUSH cycle -> next cycle: strobes 0, IO high-Z, depth = 0, rsp_valid = 0, cmd_ready = 1.
- With STACK_CHECK_EN defined, force EMPTY = 0 while depth = 0 in IDLE -> sync_err = 1 on the next edge and held until RESET. Without the macro -> sync_err stays 0.
